// File: rtl/cbs_pkg.sv
// Shared constants and stage-1 record for the pipelined carry-bypass subtractor.
// Stage-1 sign bits exist only when CBS_SUB_OVF_EN is defined.
package cbs_pkg;

    localparam int CBS_WIDTH = 16;
    localparam int CBS_BLK   = 8;

    typedef struct packed {
        logic [CBS_BLK-1:0] diff_lo;
        logic               c1;
        logic [CBS_BLK-1:0] a_hi;
        logic [CBS_BLK-1:0] nb_hi;
`ifdef CBS_SUB_OVF_EN
        logic               a_msb;
        logic               b_msb;
`endif
    } cbs_s1_t;

endpackage

// File: rtl/cbs_sub_pipe_if.sv
// Operand/result stream bundle for cbs_sub_pipe; ovf is present only when
// CBS_SUB_OVF_EN is defined.
interface cbs_sub_pipe_if #(
    parameter int WIDTH = cbs_pkg::CBS_WIDTH
);
    import cbs_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef CBS_SUB_OVF_EN
    logic             ovf;
`endif

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
`ifdef CBS_SUB_OVF_EN
        , output ovf
`endif
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
`ifdef CBS_SUB_OVF_EN
        , input ovf
`endif
    );

endinterface

// File: rtl/cbs_block.sv
// BLK-bit ripple adder block whose carry-out bypasses the ripple chain
// whenever every bit propagates.
module cbs_block
    import cbs_pkg::*;
#(
    parameter int BLK = CBS_BLK
) (
    input  logic [BLK-1:0] x,
    input  logic [BLK-1:0] y,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout
);

    logic [BLK-1:0] w_p;
    logic [BLK-1:0] w_g;
    logic [BLK:0]   w_c;

    assign w_p    = x ^ y;
    assign w_g    = x & y;
    assign w_c[0] = cin;

    for (genvar i = 0; i < BLK; i++) begin : g_bit
        assign s[i]     = w_p[i] ^ w_c[i];
        assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end

    // All-propagate block: carry-in passes straight through.
    assign cout = (&w_p) ? cin : w_c[BLK];

endmodule

// File: rtl/cbs_sub_pipe.sv
// Two-stage carry-bypass subtractor: diff = a - b mod 2^WIDTH, borrow = (a < b).
// Optional signed-overflow output enabled by defining CBS_SUB_OVF_EN.
module cbs_sub_pipe
    import cbs_pkg::*;
#(
    parameter int WIDTH = CBS_WIDTH,
    parameter int BLK   = CBS_BLK
) (
    input  logic           clk,
    input  logic           rst,
    cbs_sub_pipe_if.slave  bus
);

    logic           w_s2_adv;
    logic           w_s1_adv;
    logic           w_in_ready;
    logic           w_acc;
    logic [BLK-1:0] w_diff_lo;
    logic           w_c1;
    logic [BLK-1:0] w_diff_hi;
    logic           w_c2;
    cbs_s1_t        w_st_p0;

    logic           r_vld_p1;
    logic           r_vld_p2;
    cbs_s1_t        r_st_p1;
    logic [WIDTH-1:0] r_diff_p2;
    logic           r_borrow_p2;
`ifdef CBS_SUB_OVF_EN
    logic           r_ovf_p2;
`endif

    assign w_s2_adv   = !r_vld_p2 || bus.out_ready;
    assign w_s1_adv   = r_vld_p1 && w_s2_adv;
    assign w_in_ready = !r_vld_p1 || w_s2_adv;
    assign w_acc      = bus.in_valid && w_in_ready;

    // Stage 0 -> 1: lower block, subtraction carry-in of 1.
    cbs_block #(.BLK(BLK)) u_blk_lo (
        .x    (bus.a[BLK-1:0]),
        .y    (~bus.b[BLK-1:0]),
        .cin  (1'b1),
        .s    (w_diff_lo),
        .cout (w_c1)
    );

    always_comb begin
        w_st_p0         = '0;
        w_st_p0.diff_lo = w_diff_lo;
        w_st_p0.c1      = w_c1;
        w_st_p0.a_hi    = bus.a[WIDTH-1:BLK];
        w_st_p0.nb_hi   = ~bus.b[WIDTH-1:BLK];
`ifdef CBS_SUB_OVF_EN
        w_st_p0.a_msb   = bus.a[WIDTH-1];
        w_st_p0.b_msb   = bus.b[WIDTH-1];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            if (w_in_ready) r_vld_p1 <= bus.in_valid;
            if (w_s2_adv)   r_vld_p2 <= r_vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) r_st_p1 <= w_st_p0;
    end

    // Stage 1 -> 2: upper block chained on the registered lower carry.
    cbs_block #(.BLK(BLK)) u_blk_hi (
        .x    (r_st_p1.a_hi),
        .y    (r_st_p1.nb_hi),
        .cin  (r_st_p1.c1),
        .s    (w_diff_hi),
        .cout (w_c2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff_p2   <= '0;
            r_borrow_p2 <= 1'b0;
`ifdef CBS_SUB_OVF_EN
            r_ovf_p2    <= 1'b0;
`endif
        end else if (w_s1_adv) begin
            r_diff_p2   <= {w_diff_hi, r_st_p1.diff_lo};
            r_borrow_p2 <= ~w_c2;
`ifdef CBS_SUB_OVF_EN
            r_ovf_p2    <= (r_st_p1.a_msb != r_st_p1.b_msb) &&
                           (w_diff_hi[BLK-1] != r_st_p1.a_msb);
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_vld_p2;
    assign bus.diff      = r_diff_p2;
    assign bus.borrow    = r_borrow_p2;
`ifdef CBS_SUB_OVF_EN
    assign bus.ovf       = r_ovf_p2;
`endif

endmodule

// File: tb/tb_cbs_sub_pipe.sv
// Directed bench for cbs_sub_pipe; ovf checks compile in when CBS_SUB_OVF_EN is defined.
module tb_cbs_sub_pipe;
    import cbs_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cbs_sub_pipe_if #(.WIDTH(16)) bus ();

    cbs_sub_pipe #(.WIDTH(16), .BLK(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic single(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] ed, input logic eb, input logic eo);
        bus.a = av;
        bus.b = bv;
        bus.in_valid = 1'b1;
        chk({tag, "_in_ready"}, 16'(bus.in_ready), 16'd1);
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_ov_lat1"}, 16'(bus.out_valid), 16'd0);
        tick();
        chk({tag, "_ov"}, 16'(bus.out_valid), 16'd1);
        chk({tag, "_diff"}, bus.diff, ed);
        chk({tag, "_borrow"}, 16'(bus.borrow), 16'(eb));
`ifdef CBS_SUB_OVF_EN
        chk({tag, "_ovf"}, 16'(bus.ovf), 16'(eo));
`else
        if (eo === 1'bx) $display("note: unexpected X flag for %s", tag);
`endif
        tick();
        chk({tag, "_ov_drop"}, 16'(bus.out_valid), 16'd0);
    endtask

    logic [15:0] op_a [4];
    logic [15:0] op_b [4];
    logic [15:0] op_d [4];
    logic        op_br[4];

    initial begin
        checks   = 0;
        failures = 0;
        op_a[0] = 16'h0010; op_b[0] = 16'h0001; op_d[0] = 16'h000F; op_br[0] = 1'b0;
        op_a[1] = 16'h0100; op_b[1] = 16'h0002; op_d[1] = 16'h00FE; op_br[1] = 1'b0;
        op_a[2] = 16'h2000; op_b[2] = 16'h0003; op_d[2] = 16'h1FFD; op_br[2] = 1'b0;
        op_a[3] = 16'h0001; op_b[3] = 16'h0002; op_d[3] = 16'hFFFF; op_br[3] = 1'b1;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        tick();
        tick();
        chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_diff", bus.diff, 16'h0000);
        chk("rst_borrow", 16'(bus.borrow), 16'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
        tick();

        single("basic",    16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
        single("neg",      16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        single("bypass",   16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b0);
        single("blkcarry", 16'h1200, 16'h0001, 16'h11FF, 1'b0, 1'b0);
        single("zero_max", 16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
        single("ovf_pos",  16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
        single("ovf_neg",  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);

        // Backpressure: two accepts fill the pipe, then the input stalls.
        bus.out_ready = 1'b0;
        bus.a = op_a[0]; bus.b = op_b[0]; bus.in_valid = 1'b1;
        chk("bp_rdy0", 16'(bus.in_ready), 16'd1);
        tick();
        bus.a = op_a[1]; bus.b = op_b[1];
        chk("bp_rdy1", 16'(bus.in_ready), 16'd1);
        tick();
        bus.a = op_a[2]; bus.b = op_b[2];
        chk("bp_rdy_drop", 16'(bus.in_ready), 16'd0);
        chk("bp_ov", 16'(bus.out_valid), 16'd1);
        chk("bp_diff0", bus.diff, op_d[0]);
        for (int s = 0; s < 2; s++) begin
            tick();
            chk("bp_hold_rdy", 16'(bus.in_ready), 16'd0);
            chk("bp_hold_ov", 16'(bus.out_valid), 16'd1);
            chk("bp_hold_diff", bus.diff, op_d[0]);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rdy_back", 16'(bus.in_ready), 16'd1);
        for (int k = 1; k < 4; k++) begin
            tick();
            if (k == 1) begin
                bus.a = op_a[3]; bus.b = op_b[3];
            end else if (k == 2) begin
                bus.in_valid = 1'b0;
            end
            chk("bp_order_ov", 16'(bus.out_valid), 16'd1);
            chk("bp_order_diff", bus.diff, op_d[k]);
            chk("bp_order_borrow", 16'(bus.borrow), 16'(op_br[k]));
        end
        tick();
        chk("bp_drain", 16'(bus.out_valid), 16'd0);

        // Asynchronous reset with both stages occupied.
        bus.out_ready = 1'b0;
        bus.a = 16'h0003; bus.b = 16'h0001; bus.in_valid = 1'b1;
        tick();
        bus.a = 16'h0009; bus.b = 16'h0004;
        tick();
        bus.in_valid = 1'b0;
        chk("ar_full_ov", 16'(bus.out_valid), 16'd1);
        chk("ar_full_rdy", 16'(bus.in_ready), 16'd0);
        #2 rst = 1'b1;
        #1;
        chk("ar_ov", 16'(bus.out_valid), 16'd0);
        chk("ar_diff", bus.diff, 16'h0000);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("ar_no_stale", 16'(bus.out_valid), 16'd0);
        single("after_rst", 16'h0300, 16'h0100, 16'h0200, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
